// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME state machine with the
// one-instruction EI delay, fixed-priority arbitration, ISR vector and HALT wake.
module gb_cpu_interrupt_ctrl #(
  parameter logic [7:0] VECTOR_BASE   = 8'h40,
  parameter logic [7:0] VECTOR_STRIDE = 8'h08,
  parameter bit         IRQ_EDGE      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] irq_i,
  input  logic       last_m_cycle,
  input  logic       ei_req,
  input  logic       reti_req,
  input  logic       di_req,
  input  logic       write_interrupt_vector,
  input  logic       clear_interrupt_flag,
  input  logic       reg_sel_if,
  input  logic       reg_sel_ie,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       interrupt_queued,
  output logic [7:0] int_vector,
  output logic       ime_o,
  output logic       wake_o
);

  localparam logic [1:0] IME_OFF   = 2'd0;
  localparam logic [1:0] IME_ARMED = 2'd1;
  localparam logic [1:0] IME_ON    = 2'd2;

  logic [4:0] if_r;
  logic [7:0] ie_r;
  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [4:0] irq_prev_r;
  logic [2:0] idx_r;
  logic       vector_valid_r;
  logic [7:0] int_vector_r;
  logic [4:0] pending_s;
  logic [4:0] set_s;
  logic [4:0] if_next_s;
  logic [2:0] win_idx_s;
  logic [7:0] vec_next_s;

  // Lowest set bit wins: VBlank (bit 0) has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [4:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (p[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign pending_s  = ie_r[4:0] & if_r;
  assign set_s      = IRQ_EDGE ? (irq_i & ~irq_prev_r) : irq_i;
  assign win_idx_s  = lowest_set(pending_s);
  assign vec_next_s = VECTOR_BASE + ({5'd0, win_idx_s} * VECTOR_STRIDE);

  assign wake_o           = |pending_s;
  assign ime_o            = (state_r == IME_ARMED) || (state_r == IME_ON);
  assign interrupt_queued = ime_o & (|pending_s) & ~ei_req & ~vector_valid_r;
  assign int_vector       = int_vector_r;

  // Bus read mux; IF takes precedence when both selects are asserted.
  always_comb begin
    reg_rdata = 8'hFF;
    if (reg_sel_if) begin
      reg_rdata = {3'b111, if_r};
    end else if (reg_sel_ie) begin
      reg_rdata = ie_r;
    end else begin
      reg_rdata = 8'hFF;
    end
  end

  // Next IF: acknowledge, then bus write overrides, then new requests OR in last.
  always_comb begin
    if_next_s = if_r;
    if (clear_interrupt_flag && vector_valid_r) begin
      if_next_s[idx_r] = 1'b0;
    end else begin
      if_next_s = if_r;
    end
    if (reg_sel_if && reg_wr) begin
      if_next_s = reg_wdata[4:0];
    end else begin
      if_next_s = if_next_s;
    end
    if_next_s = if_next_s | set_s;
  end

  // IME next state; dispatch and DI dominate, RETI enables immediately.
  always_comb begin
    state_next_s = state_r;
    if (write_interrupt_vector || di_req) begin
      state_next_s = IME_OFF;
    end else if (reti_req) begin
      state_next_s = IME_ON;
    end else begin
      case (state_r)
        IME_OFF:   state_next_s = ei_req ? IME_ARMED : IME_OFF;
        IME_ARMED: state_next_s = (last_m_cycle && !ei_req) ? IME_ON : IME_ARMED;
        IME_ON:    state_next_s = IME_ON;
        default:   state_next_s = IME_OFF;
      endcase
    end
  end

  // Register file, edge history and IME state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_r       <= 5'h00;
      ie_r       <= 8'h00;
      state_r    <= IME_OFF;
      irq_prev_r <= 5'h00;
    end else begin
      if_r       <= if_next_s;
      ie_r       <= (reg_sel_ie && reg_wr) ? reg_wdata : ie_r;
      state_r    <= state_next_s;
      irq_prev_r <= irq_i;
    end
  end

  // Dispatch latch: vector chosen from pending at the vector-load cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r          <= 3'd0;
      vector_valid_r <= 1'b0;
      int_vector_r   <= 8'h00;
    end else if (write_interrupt_vector) begin
      idx_r          <= win_idx_s;
      vector_valid_r <= |pending_s;
      int_vector_r   <= (|pending_s) ? vec_next_s : 8'h00;
    end else if (clear_interrupt_flag) begin
      idx_r          <= idx_r;
      vector_valid_r <= 1'b0;
      int_vector_r   <= int_vector_r;
    end else begin
      idx_r          <= idx_r;
      vector_valid_r <= vector_valid_r;
      int_vector_r   <= int_vector_r;
    end
  end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed bench for gb_cpu_interrupt_ctrl with a rule-level reference model.
module tb_gb_cpu_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] irq_i;
  logic       last_m_cycle, ei_req, reti_req, di_req;
  logic       write_interrupt_vector, clear_interrupt_flag;
  logic       reg_sel_if, reg_sel_ie, reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       interrupt_queued;
  logic [7:0] int_vector;
  logic       ime_o, wake_o;

  int checks = 0;
  int failures = 0;

  gb_cpu_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .last_m_cycle(last_m_cycle),
    .ei_req(ei_req), .reti_req(reti_req), .di_req(di_req),
    .write_interrupt_vector(write_interrupt_vector),
    .clear_interrupt_flag(clear_interrupt_flag),
    .reg_sel_if(reg_sel_if), .reg_sel_ie(reg_sel_ie), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .interrupt_queued(interrupt_queued), .int_vector(int_vector),
    .ime_o(ime_o), .wake_o(wake_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: IME as "enabled" plus "enable still delayed by EI".
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie, m_vec;
  bit         m_enabled, m_delayed, m_vvalid, m_live;
  int         m_idx;

  always @(posedge clk) begin
    logic [4:0] p, nif;
    if (!reset) begin
      m_if = 5'h00; m_ie = 8'h00; m_prev = 5'h00; m_vec = 8'h00;
      m_enabled = 0; m_delayed = 0; m_vvalid = 0; m_idx = 0; m_live = 1;
    end else if (m_live) begin
      p = m_ie[4:0] & m_if;
      nif = m_if;
      if (clear_interrupt_flag && m_vvalid) nif[m_idx] = 1'b0;
      if (reg_sel_if && reg_wr) nif = reg_wdata[4:0];
      nif = nif | (irq_i & ~m_prev);
      if (reg_sel_ie && reg_wr) m_ie = reg_wdata;
      if (write_interrupt_vector || di_req) begin
        m_enabled = 0; m_delayed = 0;
      end else if (reti_req) begin
        m_enabled = 1; m_delayed = 0;
      end else if (ei_req) begin
        if (!m_enabled) begin m_enabled = 1; m_delayed = 1; end
      end else if (m_delayed && last_m_cycle) begin
        m_delayed = 0;
      end
      if (write_interrupt_vector) begin
        if (p != 5'h00) begin
          m_idx = 0;
          while (!p[m_idx]) m_idx++;
          m_vec = 8'(64 + 8 * m_idx);
          m_vvalid = 1;
        end else begin
          m_vec = 8'h00;
          m_vvalid = 0;
        end
      end else if (clear_interrupt_flag) begin
        m_vvalid = 0;
      end
      m_if = nif;
      m_prev = irq_i;
    end
  end

  // Compare process: every falling edge once the model has seen reset.
  always @(negedge clk) begin
    logic [4:0] p;
    logic [7:0] rd;
    if (m_live) begin
      p = m_ie[4:0] & m_if;
      rd = reg_sel_if ? {3'b111, m_if} : (reg_sel_ie ? m_ie : 8'hFF);
      chk("m_rdata", reg_rdata, rd);
      chk("m_queued", {7'd0, interrupt_queued},
          {7'd0, m_enabled && (p != 5'h00) && !ei_req && !m_vvalid});
      chk("m_vector", int_vector, m_vec);
      chk("m_ime", {7'd0, ime_o}, {7'd0, m_enabled});
      chk("m_wake", {7'd0, wake_o}, {7'd0, p != 5'h00});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_off();
    last_m_cycle = 0; ei_req = 0; reti_req = 0; di_req = 0;
    write_interrupt_vector = 0; clear_interrupt_flag = 0;
    reg_sel_if = 0; reg_sel_ie = 0; reg_wr = 0; reg_wdata = 8'h00;
  endtask

  task automatic wr_reg(input bit to_ie, input logic [7:0] d);
    reg_sel_ie = to_ie; reg_sel_if = !to_ie; reg_wr = 1; reg_wdata = d;
    tick();
    strobes_off();
  endtask

  initial begin
    m_live = 0;
    strobes_off();
    reset = 0; irq_i = 5'h1F;
    // 1. reset with all requests high
    tick(); tick();
    reg_sel_if = 1;
    #2 chk("rst_if_read", reg_rdata, 8'hE0);
    chk("rst_queued", {7'd0, interrupt_queued}, 8'h00);
    chk("rst_vector", int_vector, 8'h00);
    reg_sel_if = 0; reg_sel_ie = 1;
    #1 chk("rst_ie_read", reg_rdata, 8'h00);
    reg_sel_ie = 0;
    reset = 1; irq_i = 5'h00;
    tick();

    // 2. dispatch of VBlank with Timer also pending
    wr_reg(1, 8'h05);
    irq_i = 5'h05; tick(); irq_i = 5'h00;
    reti_req = 1; last_m_cycle = 1;
    #2 chk("t2_queued_off", {7'd0, interrupt_queued}, 8'h00);
    tick(); strobes_off();
    #2 chk("t2_queued", {7'd0, interrupt_queued}, 8'h01);
    write_interrupt_vector = 1; tick(); strobes_off();
    #2 chk("t2_vector", int_vector, 8'h40);
    chk("t2_ime", {7'd0, ime_o}, 8'h00);
    clear_interrupt_flag = 1; tick(); strobes_off();
    reg_sel_if = 1;
    #2 chk("t2_if_after_ack", reg_rdata, 8'hE4);
    reg_sel_if = 0;

    // 3. EI delay
    wr_reg(0, 8'h01); wr_reg(1, 8'h01);
    ei_req = 1; last_m_cycle = 1;
    #2 chk("t3_ei_cycle", {7'd0, interrupt_queued}, 8'h00);
    tick(); strobes_off();
    last_m_cycle = 1;
    #2 chk("t3_next_boundary", {7'd0, interrupt_queued}, 8'h01);
    tick(); strobes_off();
    #2 chk("t3_ime_on", {7'd0, ime_o}, 8'h01);

    // 4. EI then DI back-to-back
    di_req = 1; tick(); strobes_off();
    ei_req = 1; last_m_cycle = 1; tick(); strobes_off();
    di_req = 1; tick(); strobes_off();
    last_m_cycle = 1; tick(); strobes_off();
    #2 chk("t4_ime", {7'd0, ime_o}, 8'h00);
    chk("t4_queued", {7'd0, interrupt_queued}, 8'h00);
    chk("t4_wake", {7'd0, wake_o}, 8'h01);

    // 5. cancellation between queue and vector load
    wr_reg(0, 8'h04); wr_reg(1, 8'h04);
    reti_req = 1; tick(); strobes_off();
    #2 chk("t5_queued", {7'd0, interrupt_queued}, 8'h01);
    wr_reg(1, 8'h00);
    write_interrupt_vector = 1; tick(); strobes_off();
    #2 chk("t5_vector", int_vector, 8'h00);
    clear_interrupt_flag = 1; tick(); strobes_off();
    reg_sel_if = 1;
    #2 chk("t5_if_kept", reg_rdata, 8'hE4);
    reg_sel_if = 0;

    // 6. set beats same-cycle write, then reset mid-ISR
    irq_i = 5'h02; reg_sel_if = 1; reg_wr = 1; reg_wdata = 8'h00;
    tick(); strobes_off(); irq_i = 5'h00;
    reg_sel_if = 1;
    #2 chk("t6_collision", reg_rdata, 8'hE2);
    reg_sel_if = 0;
    wr_reg(1, 8'h02);
    reti_req = 1; tick(); strobes_off();
    write_interrupt_vector = 1; tick(); strobes_off();
    #2 chk("t6_vector", int_vector, 8'h48);
    reset = 0; tick(); reset = 1;
    reg_sel_if = 1;
    #2 chk("t6_rst_if", reg_rdata, 8'hE0);
    chk("t6_rst_vector", int_vector, 8'h00);
    chk("t6_rst_queued", {7'd0, interrupt_queued}, 8'h00);
    reg_sel_if = 0;
    wr_reg(1, 8'h02); wr_reg(0, 8'h02);
    clear_interrupt_flag = 1; tick(); strobes_off();
    reg_sel_if = 1;
    #2 chk("t6_ack_noop", reg_rdata, 8'hE2);
    reg_sel_if = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
